handshake_skid_slice: RTL and testbench
=======================================

# handshake_skid_slice

Two-entry registered valid/ready slice (main register plus skid register) that sits directly upstream of the combinational-ready handshake stage. It breaks both the forward (valid/data) and backward (ready) timing paths while sustaining one beat per cycle. It also reports occupancy and a running count of delivered beats for debug.

## Interface
- DATA_W, 8, payload width in bits
- CNT_W, 16, width of the delivered-beat counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- valid_pre_i  in  1  upstream beat valid
- data_pre_i  in  DATA_W  upstream payload
- ready_pre_o  out  1  registered ready to upstream
- valid_post_o  out  1  registered valid to downstream
- data_post_o  out  DATA_W  payload to downstream
- ready_post_i  in  1  downstream ready
- occupancy_o  out  2  entries held: 0, 1 or 2
- beat_count_o  out  CNT_W  number of completed downstream transfers

## Operation
- Accept at input: valid_pre_i && ready_pre_o on a rising edge. Transfer at output: valid_post_o && ready_post_i.
- States: EMPTY (occupancy 0), BUSY (main full, occupancy 1), FULL (main + skid full, occupancy 2).
- EMPTY: accept -> main <= data_pre_i, go BUSY. ready_post_i is ignored.
- BUSY:
  - accept and transfer -> main <= data_pre_i, stay BUSY.
  - accept only -> skid <= data_pre_i, go FULL.
  - transfer only -> go EMPTY.
  - neither -> hold.
- FULL: ready_pre_o = 0, so there is no accept. Transfer -> main <= skid, go BUSY. Otherwise hold.
- valid_pre_i while ready_pre_o = 0 is ignored. No data is captured and no error is flagged.
- valid_post_o = 1 in BUSY and FULL. data_post_o = main when valid_post_o = 1, and all-zero otherwise.
- ready_pre_o = 1 in EMPTY and BUSY, 0 in FULL. It is a flop output derived from next-state, never combinational from ready_post_i.
- Beats leave in strict acceptance order. No drop, no duplication.
- beat_count_o increments by 1 per output transfer. It wraps from 2^CNT_W-1 to 0 silently.

## Timing
- Reset values while rst = 1:
  - state EMPTY
  - valid_post_o 0, data_post_o 0
  - ready_pre_o 0
  - occupancy_o 0, beat_count_o 0
  - main and skid registers 0
- ready_pre_o rises on the first rising edge after rst deasserts.
- Latency: a beat accepted at edge N appears on valid_post_o/data_post_o after edge N and can transfer at edge N+1.
- Throughput: 1 beat/cycle sustained while ready_post_i stays high.
- Ready path: ready_pre_o falls one cycle after the stall that fills the skid. The beat accepted during that cycle lands in skid and is not lost.
- After FULL -> BUSY, ready_pre_o is high again in the following cycle.
- Output stability: while valid_post_o && !ready_post_i, valid_post_o and data_post_o hold unchanged.
- Reset mid-operation: both entries are discarded immediately (asynchronously), outputs go to their reset values, and the counter clears.

## Structure
- Shared package holds:
  - the state typedef (EMPTY, BUSY, FULL, 2-bit encoding)
  - the default DATA_W = 8 and CNT_W = 16 constants used by all handshake stages
- No sub-module: one flat module containing the state register, main/skid registers and counter.

## Test plan
- Reset and idle: hold rst for 3 cycles, then release. Check all outputs are 0 during reset, ready_pre_o = 1 one edge after release, and valid_post_o stays 0 with no input.
- Streaming: drive 0x01..0x10 back-to-back with ready_post_i = 1. Check output 0x01..0x10 in order, one per cycle, 1-cycle latency, and beat_count_o = 16.
- Skid fill: stream 0xA0, 0xA1, 0xA2 with ready_post_i low from the cycle 0xA0 appears. Check occupancy reaches 2, ready_pre_o drops, 0xA2 is not accepted and is held by the source, and after ready_post_i rises the output is 0xA0, 0xA1, 0xA2 with nothing lost or duplicated.
- Random backpressure: 1000 random beats with random valid_pre_i and ready_post_i. The scoreboard checks ordering, output stability during stalls, and occupancy_o against its model.
- Counter wrap: with CNT_W = 4, send 17 beats and check beat_count_o = 1.
- Mid-operation reset: assert rst while FULL (0x55 in main, 0x66 in skid). Check valid_post_o drops asynchronously, and after release the first output beat is new data, not 0x55 or 0x66.

Source files
------------

// File: rtl/handshake_skid_slice_pkg.sv
// Shared types and default widths for the valid/ready handshake stages.
// The state encoding doubles as the basis for the occupancy readout.
package handshake_skid_slice_pkg;

    localparam int HS_DATA_W = 8;
    localparam int HS_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } hsState_t;

    // Number of beats a slice holds while sitting in the given state.
    function automatic logic [1:0] occupancyOf(input hsState_t state);
        case (state)
            ST_BUSY: return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/handshake_skid_slice.sv
// Two-entry registered valid/ready slice: a main register feeding the output
// and a skid register catching the beat accepted while ready is still high.
module handshake_skid_slice
    import handshake_skid_slice_pkg::*;
#(
    parameter int DATA_W = HS_DATA_W,
    parameter int CNT_W  = HS_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    input  logic [DATA_W-1:0] data_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    output logic [DATA_W-1:0] data_post_o,
    input  logic              ready_post_i,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  beat_count_o
);

    hsState_t          r_state;
    hsState_t          w_nextState;
    logic              r_readyPre;
    logic              r_validPost;
    logic [1:0]        r_occupancy;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_beatCount;

    logic w_accept;
    logic w_transfer;
    logic w_loadMainIn;
    logic w_loadMainSkid;
    logic w_loadSkid;
    logic w_clearMain;

    assign w_accept   = valid_pre_i && r_readyPre;
    assign w_transfer = r_validPost && ready_post_i;

    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        w_clearMain    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_loadMainIn = 1'b1;
                    w_nextState  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_accept && w_transfer) begin
                    w_loadMainIn = 1'b1;
                end else if (w_accept) begin
                    w_loadSkid  = 1'b1;
                    w_nextState = ST_FULL;
                end else if (w_transfer) begin
                    // Clearing main keeps the payload at zero whenever valid is low.
                    w_clearMain = 1'b1;
                    w_nextState = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_transfer) begin
                    w_loadMainSkid = 1'b1;
                    w_nextState    = ST_BUSY;
                end
            end
            default: begin
                w_clearMain = 1'b1;
                w_nextState = ST_EMPTY;
            end
        endcase
    end

    // Handshake flags come from the next state, so neither ready nor valid
    // has a combinational path through the slice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_readyPre  <= 1'b0;
            r_validPost <= 1'b0;
            r_occupancy <= 2'd0;
        end else begin
            r_state     <= w_nextState;
            r_readyPre  <= (w_nextState != ST_FULL);
            r_validPost <= (w_nextState != ST_EMPTY);
            r_occupancy <= occupancyOf(w_nextState);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_loadMainIn) begin
                r_main <= data_pre_i;
            end else if (w_loadMainSkid) begin
                r_main <= r_skid;
            end else if (w_clearMain) begin
                r_main <= '0;
            end
            if (w_loadSkid) begin
                r_skid <= data_pre_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beatCount <= '0;
        end else if (w_transfer) begin
            r_beatCount <= r_beatCount + CNT_W'(1);
        end
    end

    assign ready_pre_o  = r_readyPre;
    assign valid_post_o = r_validPost;
    assign data_post_o  = r_main;
    assign occupancy_o  = r_occupancy;
    assign beat_count_o = r_beatCount;

endmodule

// File: tb/tb_handshake_skid_slice.sv
// Scoreboard bench for handshake_skid_slice: a queue model of accepted beats
// predicts every output, plus a narrow-counter instance for the wrap case.
module tb_handshake_skid_slice;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic       validPre  = 1'b0;
   logic [7:0] dataPre   = 8'h00;
   logic       readyPost = 1'b0;
   logic       readyPre;
   logic       validPost;
   logic [7:0] dataPost;
   logic [1:0] occ;
   logic [15:0] beatCount;

   logic       validPreW  = 1'b0;
   logic [7:0] dataPreW   = 8'h00;
   logic       readyPostW = 1'b0;
   logic       readyPreW;
   logic       validPostW;
   logic [7:0] dataPostW;
   logic [1:0] occW;
   logic [3:0] beatCountW;

   int checks = 0;
   int errors = 0;

   logic [7:0] expQ[$];
   int         mOcc    = 0;
   bit         mReady  = 1'b0;
   int         mCount  = 0;
   bit         lastAcc = 1'b0;

   handshake_skid_slice #(.DATA_W(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_pre_i  (validPre),
      .data_pre_i   (dataPre),
      .ready_pre_o  (readyPre),
      .valid_post_o (validPost),
      .data_post_o  (dataPost),
      .ready_post_i (readyPost),
      .occupancy_o  (occ),
      .beat_count_o (beatCount)
   );

   handshake_skid_slice #(.DATA_W(8), .CNT_W(4)) dutWrap (
      .clk          (clk),
      .rst          (rst),
      .valid_pre_i  (validPreW),
      .data_pre_i   (dataPreW),
      .ready_pre_o  (readyPreW),
      .valid_post_o (validPostW),
      .data_post_o  (dataPostW),
      .ready_post_i (readyPostW),
      .occupancy_o  (occW),
      .beat_count_o (beatCountW)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance n edges and land 2 time units after the last one, where inputs change.
   task automatic cycle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Present a beat and hold it, as a well-behaved source would, until accepted.
   task automatic applyStimulus(input logic [7:0] d, input int maxCycles);
      int n = 0;
      validPre = 1'b1;
      dataPre  = d;
      do begin
         cycle(1);
         n++;
      end while (!lastAcc && n < maxCycles);
      if (!lastAcc) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: beat 0x%0h not accepted within %0d cycles", d, maxCycles);
      end
   endtask

   // Reference model: a FIFO of at most two beats; ready means fewer than two held,
   // except for the first edge after reset when ready is still low.
   initial begin : modelProc
      bit acc;
      bit xfer;
      forever begin
         @(posedge clk);
         if (rst) begin
            expQ.delete();
            mOcc    = 0;
            mReady  = 1'b0;
            mCount  = 0;
            lastAcc = 1'b0;
         end else begin
            xfer = (mOcc > 0) && readyPost;
            acc  = validPre && mReady;
            if (acc) expQ.push_back(dataPre);
            mOcc = mOcc + int'(acc) - int'(xfer);
            if (xfer) mCount++;
            mReady  = (mOcc < 2);
            lastAcc = acc;
         end
      end
   end

   // Monitor: compares every output mid-cycle and retires a beat when it transfers.
   initial begin : monitorProc
      bit         prevStall;
      logic [7:0] prevData;
      prevStall = 1'b0;
      prevData  = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checkOutput("ready_pre", readyPre, mReady);
            checkOutput("valid_post", validPost, mOcc > 0);
            checkOutput("occupancy", occ, mOcc);
            checkOutput("beat_count", beatCount, mCount & 32'hFFFF);
            if (mOcc > 0) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL data_post: got 0x%0h expected no beat at %0t", dataPost, $time);
               end else begin
                  checkOutput("data_post", dataPost, expQ[0]);
               end
               if (prevStall) checkOutput("stall_data_hold", dataPost, prevData);
               prevStall = !readyPost;
               prevData  = dataPost;
               if (readyPost && expQ.size() > 0) void'(expQ.pop_front());
            end else begin
               checkOutput("data_idle", dataPost, 32'h0);
               prevStall = 1'b0;
            end
         end else begin
            prevStall = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int accepted;
      int cyc;
      int nW;
      bit rW;

      // Reset and idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready", readyPre, 0);
      checkOutput("reset_valid", validPost, 0);
      checkOutput("reset_data", dataPost, 0);
      checkOutput("reset_occ", occ, 0);
      checkOutput("reset_count", beatCount, 0);
      cycle(1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", readyPre, 1);
      #1;
      cycle(3);

      // Streaming 0x01..0x10 with downstream always ready
      readyPost = 1'b1;
      for (int i = 1; i <= 16; i++) applyStimulus(8'(i), 10);
      validPre = 1'b0;
      checkOutput("stream_count_pipelined", beatCount, 15);
      cycle(1);
      checkOutput("stream_count", beatCount, 16);
      cycle(2);

      // Skid fill with downstream stalled
      readyPost = 1'b0;
      applyStimulus(8'hA0, 10);
      applyStimulus(8'hA1, 10);
      validPre = 1'b1;
      dataPre  = 8'hA2;
      checkOutput("skid_occ", occ, 2);
      checkOutput("skid_ready_low", readyPre, 0);
      checkOutput("skid_head", dataPost, 8'hA0);
      cycle(3);
      checkOutput("skid_hold_occ", occ, 2);
      readyPost = 1'b1;
      applyStimulus(8'hA2, 10);
      validPre = 1'b0;
      cycle(4);
      checkOutput("skid_drain_count", beatCount, 19);
      checkOutput("skid_drain_occ", occ, 0);

      // Random valid and backpressure, source holds a beat until accepted
      accepted = 0;
      cyc      = 0;
      while (accepted < 1000 && cyc < 20000) begin
         if (!validPre || lastAcc) begin
            validPre = ($urandom_range(0, 9) < 7);
            dataPre  = 8'($urandom);
         end
         readyPost = ($urandom_range(0, 9) < 6);
         cycle(1);
         cyc++;
         if (lastAcc) accepted++;
      end
      validPre = 1'b0;
      checkOutput("random_accepted", accepted, 1000);
      readyPost = 1'b1;
      cycle(5);
      checkOutput("random_drain_occ", occ, 0);
      checkOutput("random_count", beatCount, 1019);

      // Counter wrap on the 4-bit instance: 17 transfers leave 1
      readyPostW = 1'b1;
      nW = 0;
      cyc = 0;
      while (nW < 17 && cyc < 100) begin
         validPreW = 1'b1;
         dataPreW  = 8'(nW);
         rW = readyPreW;
         cycle(1);
         cyc++;
         if (rW) nW++;
      end
      validPreW = 1'b0;
      cycle(3);
      checkOutput("wrap_beats_sent", nW, 17);
      checkOutput("wrap_count", beatCountW, 1);
      checkOutput("wrap_occ", occW, 0);

      // Reset while FULL discards both entries
      readyPost = 1'b0;
      applyStimulus(8'h55, 10);
      applyStimulus(8'h66, 10);
      validPre = 1'b0;
      checkOutput("prereset_occ", occ, 2);
      checkOutput("prereset_data", dataPost, 8'h55);
      rst = 1'b1;
      #1;
      checkOutput("midreset_valid", validPost, 0);
      checkOutput("midreset_data", dataPost, 0);
      checkOutput("midreset_occ", occ, 0);
      checkOutput("midreset_ready", readyPre, 0);
      checkOutput("midreset_count", beatCount, 0);
      #1;
      cycle(2);
      rst = 1'b0;
      cycle(1);
      applyStimulus(8'h77, 10);
      validPre = 1'b0;
      checkOutput("postreset_valid", validPost, 1);
      checkOutput("postreset_first", dataPost, 8'h77);
      readyPost = 1'b1;
      cycle(3);
      checkOutput("postreset_count", beatCount, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
